rvl_reg_exerciser: RTL and testbench

Parametrised traffic generator and checker for the Reveal controller user register interface (rvl_ctrl_mod usr_* port).
- Sweeps NUM_REGS registers, one access per programmable tick.
- Three modes: write-only, read-only, and write-then-readback verify.
- Captures read data for display and keeps pass and error statistics.
- Sits between the top-level counter/LED logic and rvl_ctrl_mod.

---
 rtl/rvl_ex_pkg.sv | 19 +
 rtl/rvl_tick_gen.sv | 24 ++
 rtl/rvl_reg_exerciser.sv | 128 ++++++++++++
 tb/tb_rvl_reg_exerciser.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvl_ex_pkg.sv
// Shared types and constants for the Reveal user-register exerciser.
// Both the FSM state encoding and the mode codes are defined here.
package rvl_ex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_WR        = 3'd2,
        ST_RD        = 3'd3,
        ST_RD_WAIT   = 3'd4,
        ST_CHK       = 3'd5,
        ST_ADV       = 3'd6
    } state_t;

    localparam logic [1:0] MODE_WRITE  = 2'd0;
    localparam logic [1:0] MODE_READ   = 2'd1;
    localparam logic [1:0] MODE_VERIFY = 2'd2;

endpackage

// File: rtl/rvl_tick_gen.sv
// Access pacing: counts 2**PERIOD_WIDTH cycles while enabled and flags the
// last count as tick. Dropping enable restarts the period from zero.
module rvl_tick_gen #(
    parameter int PERIOD_WIDTH = 26
) (
    input  logic usr_clk,
    input  logic usr_rst,
    input  logic enable,
    output logic tick
);

    logic [PERIOD_WIDTH-1:0] cnt;

    always_ff @(posedge usr_clk) begin
        if (usr_rst || !enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PERIOD_WIDTH'(1);
        end
    end

    assign tick = enable && (&cnt);

endmodule

// File: rtl/rvl_reg_exerciser.sv
// Sweeps the Reveal user register port with write, read or write-then-verify
// accesses, one per tick, and keeps pass and mismatch statistics.
import rvl_ex_pkg::*;

module rvl_reg_exerciser #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_REGS     = 16,
    parameter int PERIOD_WIDTH = 26,
    parameter int RD_LATENCY   = 1,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                  usr_clk,
    input  logic                  usr_rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  clr_err,
    output logic                  usr_ce,
    output logic                  usr_we,
    output logic [ADDR_WIDTH-1:0] usr_addr,
    output logic [DATA_WIDTH-1:0] usr_wdata,
    input  logic [DATA_WIDTH-1:0] usr_rdata,
    output logic [DATA_WIDTH-1:0] rd_data_last,
    output logic [15:0]           pass_cnt,
    output logic                  pass_done,
    output logic [ERR_WIDTH-1:0]  err_cnt,
    output logic                  err_flag,
    output logic                  busy,
    output state_t                dbg_state
);

    localparam int LW        = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    localparam int WAIT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    state_t                state, state_nx;
    logic [1:0]            mode_q;
    logic [LW-1:0]         wait_cnt;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  tick;
    logic                  last_reg;
    logic                  mismatch;

    rvl_tick_gen #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_tick (
        .usr_clk(usr_clk),
        .usr_rst(usr_rst),
        .enable (enable),
        .tick   (tick)
    );

    assign pattern  = DATA_WIDTH'(pass_cnt) + DATA_WIDTH'(usr_addr);
    assign last_reg = (usr_addr == ADDR_WIDTH'(NUM_REGS - 1));
    assign mismatch = (state == ST_CHK) && (mode_q == MODE_VERIFY) && (usr_rdata != pattern);

    // Register port protocol: a strobe is one cycle of usr_ce; usr_we selects
    // write. Read data is valid exactly RD_LATENCY cycles after the read strobe.
    assign usr_ce    = (state == ST_WR) || (state == ST_RD);
    assign usr_we    = (state == ST_WR);
    assign usr_wdata = (state == ST_WR) ? pattern : '0;
    assign pass_done = (state == ST_ADV) && last_reg;
    assign busy      = (state != ST_IDLE) && (state != ST_WAIT_TICK);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (enable) state_nx = ST_WAIT_TICK;
            ST_WAIT_TICK: begin
                if (!enable) begin
                    state_nx = ST_IDLE;
                end else if (tick) begin
                    // Reserved mode 3 falls through to a plain read.
                    state_nx = (mode == MODE_WRITE || mode == MODE_VERIFY) ? ST_WR : ST_RD;
                end
            end
            ST_WR:        state_nx = (mode_q == MODE_VERIFY) ? ST_RD : ST_ADV;
            ST_RD:        state_nx = (RD_LATENCY == 1) ? ST_CHK : ST_RD_WAIT;
            ST_RD_WAIT:   if (wait_cnt == LW'(WAIT_LAST)) state_nx = ST_CHK;
            ST_CHK:       state_nx = ST_ADV;
            ST_ADV:       state_nx = enable ? ST_WAIT_TICK : ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge usr_clk) begin
        if (usr_rst) begin
            state        <= ST_IDLE;
            mode_q       <= '0;
            wait_cnt     <= '0;
            usr_addr     <= '0;
            pass_cnt     <= '0;
            rd_data_last <= '0;
            err_cnt      <= '0;
            err_flag     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_WAIT_TICK && tick) mode_q <= mode;
            if (state == ST_RD) begin
                wait_cnt <= '0;
            end else if (state == ST_RD_WAIT) begin
                wait_cnt <= wait_cnt + LW'(1);
            end
            if (state == ST_CHK) rd_data_last <= usr_rdata;
            // A mismatch in the same cycle as a clear restarts the count at one.
            if (mismatch) begin
                err_flag <= 1'b1;
                if (clr_err) begin
                    err_cnt <= ERR_WIDTH'(1);
                end else if (!(&err_cnt)) begin
                    err_cnt <= err_cnt + ERR_WIDTH'(1);
                end
            end else if (clr_err) begin
                err_cnt  <= '0;
                err_flag <= 1'b0;
            end
            if (state == ST_ADV) begin
                if (last_reg) begin
                    usr_addr <= '0;
                    pass_cnt <= pass_cnt + 16'd1;
                end else begin
                    usr_addr <= usr_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rvl_reg_exerciser.sv
// Bench for rvl_reg_exerciser: a 4-entry register device with 2-cycle read
// latency plus a timeline model predicting every output cycle by cycle.
module tb_rvl_reg_exerciser;
    import rvl_ex_pkg::*;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int NR      = 4;
    localparam int PW      = 4;
    localparam int RL      = 2;
    localparam int EW      = 2;
    localparam int PERIOD  = 16;
    localparam int ERR_MAX = 3;

    // ---------------- clock / reset / DUT ----------------
    logic          usr_clk;
    logic          usr_rst;
    logic          enable;
    logic [1:0]    mode;
    logic          clr_err;
    logic          usr_ce;
    logic          usr_we;
    logic [AW-1:0] usr_addr;
    logic [DW-1:0] usr_wdata;
    logic [DW-1:0] usr_rdata;
    logic [DW-1:0] rd_data_last;
    logic [15:0]   pass_cnt;
    logic          pass_done;
    logic [EW-1:0] err_cnt;
    logic          err_flag;
    logic          busy;
    state_t        dbg_state;

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    rvl_reg_exerciser #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .PERIOD_WIDTH(PW), .RD_LATENCY(RL), .ERR_WIDTH(EW)
    ) dut (
        .usr_clk(usr_clk), .usr_rst(usr_rst), .enable(enable), .mode(mode),
        .clr_err(clr_err), .usr_ce(usr_ce), .usr_we(usr_we), .usr_addr(usr_addr),
        .usr_wdata(usr_wdata), .usr_rdata(usr_rdata), .rd_data_last(rd_data_last),
        .pass_cnt(pass_cnt), .pass_done(pass_done), .err_cnt(err_cnt),
        .err_flag(err_flag), .busy(busy), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- register device ----------------
    logic [DW-1:0] dev_mem [NR];
    logic [DW-1:0] pre_vals [NR];
    logic          do_preload;
    logic          fault_en;
    logic          p1_v = 1'b0;
    logic [DW-1:0] p1_d = '0;

    function automatic logic [DW-1:0] corrupt(input logic [AW-1:0] a);
        return (fault_en && a == 2) ? 16'h0001 : 16'h0000;
    endfunction

    always @(posedge usr_clk) begin
        if (do_preload) begin
            for (int i = 0; i < NR; i++) dev_mem[i] <= pre_vals[i];
        end else if (usr_ce && usr_we) begin
            dev_mem[usr_addr[1:0]] <= usr_wdata;
        end
        p1_v      <= usr_ce && !usr_we;
        p1_d      <= dev_mem[usr_addr[1:0]] ^ corrupt(usr_addr);
        usr_rdata <= p1_v ? p1_d : DW'($urandom);
    end

    // ---------------- behavioural model + compare ----------------
    function automatic logic [DW-1:0] pat(input int p, input int a);
        return DW'((p + a) % 65536);
    endfunction

    bit            chk_en = 0;
    int            cyc = 0;
    int            en_start = -1;
    int            start_c = -1000, wr_at = -1, rd_at = -1, adv_at = -1, chk_at = -1;
    logic [1:0]    acc_mode = 2'd0;
    int            m_pass = 0, m_addr = 0, m_err = 0;
    logic          m_flag = 1'b0;
    logic [DW-1:0] m_last = '0, chk_val = '0, chk_pat = '0;
    bit            chk_ver = 0;

    always @(negedge usr_clk) begin
        bit            e_ce, e_we, e_busy, e_pd, mism;
        logic [DW-1:0] e_wd;
        cyc++;
        // An access begins every PERIOD cycles counted from enable rising.
        if (en_start >= 0 && cyc > en_start && (cyc - en_start) % PERIOD == 0) begin
            start_c  = cyc;
            acc_mode = mode;
            wr_at    = (mode == 0 || mode == 2) ? cyc : -1;
            rd_at    = (mode == 0) ? -1 : ((mode == 2) ? cyc + 1 : cyc);
            adv_at   = (mode == 0) ? cyc + 1 : ((mode == 2) ? cyc + 2 + RL : cyc + 1 + RL);
        end
        e_we   = (cyc == wr_at);
        e_ce   = e_we || (cyc == rd_at);
        e_wd   = e_we ? pat(m_pass, m_addr) : '0;
        e_busy = (cyc >= start_c) && (cyc <= adv_at);
        e_pd   = (cyc == adv_at) && (m_addr == NR - 1);
        if (chk_en) begin
            check("usr_ce", usr_ce, e_ce);
            check("usr_we", usr_we, e_we);
            check("usr_wdata", usr_wdata, e_wd);
            check("usr_addr", usr_addr, m_addr);
            check("pass_cnt", pass_cnt, m_pass);
            check("pass_done", pass_done, e_pd);
            check("rd_data_last", rd_data_last, m_last);
            check("err_cnt", err_cnt, m_err);
            check("err_flag", err_flag, m_flag);
            check("busy", busy, e_busy);
        end
        if (usr_rst) begin
            m_pass = 0; m_addr = 0; m_err = 0; m_flag = 1'b0; m_last = '0;
            start_c = -1000; wr_at = -1; rd_at = -1; adv_at = -1; chk_at = -1;
            en_start = enable ? cyc + 1 : -1;
        end else begin
            mism = 0;
            if (cyc == chk_at) begin
                m_last = chk_val;
                mism   = chk_ver && (chk_val != chk_pat);
            end
            if (mism) begin
                m_flag = 1'b1;
                m_err  = clr_err ? 1 : ((m_err == ERR_MAX) ? ERR_MAX : m_err + 1);
            end else if (clr_err) begin
                m_err  = 0;
                m_flag = 1'b0;
            end
            if (cyc == rd_at) begin
                chk_at  = cyc + RL;
                chk_val = dev_mem[m_addr % NR] ^ corrupt(AW'(m_addr));
                chk_pat = pat(m_pass, m_addr);
                chk_ver = (acc_mode == 2);
            end
            if (cyc == adv_at) begin
                if (m_addr == NR - 1) begin
                    m_addr = 0;
                    m_pass = (m_pass + 1) % 65536;
                end else begin
                    m_addr++;
                end
            end
            if (!enable) en_start = -1;
            else if (en_start < 0) en_start = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rst_dut();
        @(posedge usr_clk); #1;
        usr_rst = 1'b1;
        enable  = 1'b0;
        @(posedge usr_clk); #1;
        usr_rst = 1'b0;
    endtask

    task automatic wait_pd(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge usr_clk);
            if (pass_done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check("wait_pass_done", 32'(ok), 32'd1);
    endtask

    task automatic wait_acc(input bit we, input int addr, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge usr_clk);
            if (usr_ce === 1'b1 && usr_we === we && usr_addr == addr) begin
                ok = 1;
                break;
            end
        end
        check("wait_access", 32'(ok), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        usr_rst = 1'b1; enable = 1'b0; mode = 2'd0; clr_err = 1'b0; fault_en = 1'b0;
        for (int i = 0; i < NR; i++) pre_vals[i] = '0;
        do_preload = 1'b1;
        repeat (3) @(posedge usr_clk);
        #1;
        usr_rst = 1'b0; do_preload = 1'b0; chk_en = 1;
        @(negedge usr_clk);
        check("rst_ce", usr_ce, 0);
        check("rst_addr", usr_addr, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // WRITE sweep
        mode = 2'd0;
        @(posedge usr_clk); #1 enable = 1'b1;
        wait_acc(1, 0, 40);
        check("wr_first_wdata", usr_wdata, 16'd0);
        wait_pd(200);
        @(negedge usr_clk);
        check("wr_pass1", pass_cnt, 16'd1);
        check("wr_addr_wrap", usr_addr, 0);
        wait_acc(1, 3, 100);
        check("wr_pass2_a3", usr_wdata, 16'd4);
        wait_pd(100);
        rst_dut();

        // VERIFY clean
        mode = 2'd2;
        @(posedge usr_clk); #1 enable = 1'b1;
        wait_pd(200);
        check("ver_last_p0", rd_data_last, 16'd3);
        wait_pd(100);
        check("ver_last_p1", rd_data_last, 16'd4);
        @(negedge usr_clk);
        check("ver_pass2", pass_cnt, 16'd2);
        check("ver_err0", err_cnt, 0);
        check("ver_flag0", err_flag, 0);
        rst_dut();

        // VERIFY with corrupted readback at addr 2
        fault_en = 1'b1;
        mode = 2'd2;
        @(posedge usr_clk); #1 enable = 1'b1;
        wait_pd(200);
        check("flt_err1", err_cnt, 1);
        repeat (4) wait_pd(100);
        @(negedge usr_clk);
        check("flt_sat", err_cnt, 3);
        check("flt_flag", err_flag, 1);
        check("flt_pass5", pass_cnt, 16'd5);
        wait_acc(0, 2, 100);
        @(posedge usr_clk); #1;
        @(posedge usr_clk); #1 clr_err = 1'b1;
        @(posedge usr_clk); #1 clr_err = 1'b0;
        @(negedge usr_clk);
        check("clr_with_mism_cnt", err_cnt, 1);
        check("clr_with_mism_flag", err_flag, 1);
        rst_dut();
        fault_en = 1'b0;

        // READ from preloaded registers
        pre_vals[0] = 16'hA5A5; pre_vals[1] = 16'h5A5A;
        pre_vals[2] = 16'h1234; pre_vals[3] = 16'hBEEF;
        @(posedge usr_clk); #1 do_preload = 1'b1;
        @(posedge usr_clk); #1 do_preload = 1'b0;
        mode = 2'd1;
        enable = 1'b1;
        wait_pd(200);
        check("rd_last_beef", rd_data_last, 16'hBEEF);
        check("rd_err_unch", err_cnt, 0);

        // Reserved mode as read; enable dropped in RD_WAIT at addr 1
        @(posedge usr_clk); #1 mode = 2'd3;
        wait_acc(0, 1, 100);
        @(posedge usr_clk); #1 enable = 1'b0;
        repeat (6) @(posedge usr_clk);
        @(negedge usr_clk);
        check("drop_ce", usr_ce, 0);
        check("drop_addr", usr_addr, 2);
        check("drop_busy", busy, 0);
        check("drop_state", dbg_state, ST_IDLE);
        check("drop_last", rd_data_last, 16'h5A5A);
        @(posedge usr_clk); #1 enable = 1'b1;
        gap = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge usr_clk);
            if (usr_ce === 1'b1) begin
                gap = i;
                break;
            end
        end
        check("resume_gap", gap, 16);
        check("resume_addr", usr_addr, 2);
        rst_dut();

        // Reset during WR at addr 3 of pass 5
        mode = 2'd0;
        @(posedge usr_clk); #1 enable = 1'b1;
        wait_pd(200);
        repeat (4) wait_pd(100);
        wait_acc(1, 2, 100);
        check("pre_rst_pass", pass_cnt, 16'd5);
        repeat (16) @(posedge usr_clk);
        #1;
        usr_rst = 1'b1;
        enable  = 1'b0;
        @(negedge usr_clk);
        check("pre_rst_we", usr_we, 1);
        check("pre_rst_addr", usr_addr, 3);
        @(posedge usr_clk); #1 usr_rst = 1'b0;
        @(negedge usr_clk);
        check("post_rst_ce", usr_ce, 0);
        check("post_rst_we", usr_we, 0);
        check("post_rst_addr", usr_addr, 0);
        check("post_rst_pass", pass_cnt, 0);
        check("post_rst_err", err_cnt, 0);
        check("post_rst_state", dbg_state, ST_IDLE);

        repeat (5) @(posedge usr_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
